// File: rtl/mem_sig_monitor_pkg.sv
// Shared types and address map for the data-memory signalling monitor.
package mem_sig_monitor_pkg;

  localparam logic [31:0] ADDR_STOP_SIG = 32'h0000_0000;
  localparam logic [31:0] ADDR_TRAP_SIG = 32'h0000_0008;
  localparam logic [31:0] ADDR_INT_DUMP = 32'h0000_0010;
  localparam logic [31:0] ADDR_FP_DUMP  = 32'h0000_0018;

  localparam int DUMP_DATA_W = 64;

  typedef struct packed {
    logic                   is_float;
    logic [4:0]             idx;
    logic [DUMP_DATA_W-1:0] data;
  } dump_rec_t;

  typedef enum logic [1:0] {
    REASON_NONE   = 2'd0,
    REASON_STOP   = 2'd1,
    REASON_TRAP   = 2'd2,
    REASON_SIMLEN = 2'd3
  } stop_reason_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mon_state_e;

  // Register index walk: 31 wraps back to the first loggable register.
  function automatic logic [4:0] next_idx(input logic [4:0] idx, input logic [4:0] wrap_to);
    return (idx == 5'd31) ? wrap_to : idx + 5'd1;
  endfunction

endpackage

// File: rtl/mem_sig_fifo.sv
// Generic sync FIFO of type T; head is read from flops, pushed data is visible one cycle later.
// Push when full is refused unless a pop happens in the same cycle; pop_dat is zero while empty.
module mem_sig_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_vld,
  input  T     push_dat,
  input  logic pop_rdy,
  output T     pop_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop_rdy && !empty;
  assign do_push = push_vld && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_comb begin
    pop_dat = '0;
    if (!empty) pop_dat = mem[rd_ptr];
  end

endmodule

// File: rtl/mem_sig_monitor.sv
// Decodes stop/trap/dump writes on the data-memory port; done after a STOP_DELAY drain, dumps buffered
// with valid/ready (record visible one cycle after capture, dropped + dump_ovf_o when full). MEM_SIG_MONITOR_SIMLEN_EN adds the cycle limit.
module mem_sig_monitor
  import mem_sig_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int STOP_DELAY      = 50,
  parameter int DUMP_FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_mem_req_i,
  input  logic                  data_mem_we_i,
  input  logic [ADDR_WIDTH-1:0] data_mem_addr_i,
  input  logic [DATA_WIDTH-1:0] data_mem_wdata_i,
  input  logic                  dontstop_on_trap_i,
  input  logic [31:0]           simlen_i,
  output logic                  trap_seen_o,
  output logic                  done_o,
  output logic [1:0]            reason_o,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic                  dump_is_float_o,
  output logic [4:0]            dump_idx_o,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic                  dump_ovf_o
);

  mon_state_e             state;
  stop_reason_e           reason_q;
  logic [31:0]            drain_cnt;
  logic [4:0]             int_idx;
  logic [4:0]             fp_idx;
  logic                   done_q;
  logic                   trap_seen_q;
  logic                   ovf_q;
  logic                   wr_vld;
  logic                   hit_stop;
  logic                   hit_trap;
  logic                   hit_int;
  logic                   hit_fp;
  logic                   simlen_hit;
  logic                   decode_en;
  logic                   push_vld;
  logic                   fifo_full;
  logic                   fifo_empty;
  dump_rec_t              push_rec;
  dump_rec_t              head_rec;
  logic [DUMP_DATA_W-1:0] wdata_ext;

  assign wr_vld    = data_mem_req_i && data_mem_we_i;
  assign hit_stop  = wr_vld && (data_mem_addr_i == ADDR_WIDTH'(ADDR_STOP_SIG));
  assign hit_trap  = wr_vld && (data_mem_addr_i == ADDR_WIDTH'(ADDR_TRAP_SIG));
  assign hit_int   = wr_vld && (data_mem_addr_i == ADDR_WIDTH'(ADDR_INT_DUMP));
  assign hit_fp    = wr_vld && (data_mem_addr_i == ADDR_WIDTH'(ADDR_FP_DUMP));
  assign wdata_ext = DUMP_DATA_W'(data_mem_wdata_i);

`ifdef MEM_SIG_MONITOR_SIMLEN_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt <= '0;
    end else if (state == ST_RUN && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign simlen_hit = (state == ST_RUN) && (simlen_i != 32'd0) && (cycle_cnt == simlen_i - 32'd1);
`else
  logic unused_simlen;
  assign unused_simlen = ^simlen_i;
  assign simlen_hit    = 1'b0;
`endif

  // The simlen edge swallows any write that lands on it.
  assign decode_en = (state == ST_RUN) && !simlen_hit;

  always_comb begin
    push_rec = '0;
    push_vld = 1'b0;
    if (decode_en && hit_int) begin
      push_vld          = 1'b1;
      push_rec.is_float = 1'b0;
      push_rec.idx      = int_idx;
      push_rec.data     = wdata_ext & DUMP_DATA_W'(32'hFFFF_FFFF);
    end else if (decode_en && hit_fp) begin
      push_vld          = 1'b1;
      push_rec.is_float = 1'b1;
      push_rec.idx      = fp_idx;
      push_rec.data     = wdata_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      done_q      <= 1'b0;
      reason_q    <= REASON_NONE;
      trap_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
      int_idx     <= 5'd1;
      fp_idx      <= 5'd0;
    end else begin
      // A full FIFO is never empty, so only a missing ready makes the push drop.
      if (push_vld && fifo_full && !dump_ready_i) ovf_q <= 1'b1;
      if (decode_en && hit_int) int_idx <= next_idx(int_idx, 5'd1);
      if (decode_en && hit_fp)  fp_idx  <= next_idx(fp_idx, 5'd0);

      case (state)
        ST_RUN: begin
          if (simlen_hit) begin
            state    <= ST_DONE;
            done_q   <= 1'b1;
            reason_q <= REASON_SIMLEN;
          end else if (hit_stop) begin
            state     <= ST_DRAIN;
            drain_cnt <= 32'(STOP_DELAY);
            reason_q  <= REASON_STOP;
          end else if (hit_trap) begin
            trap_seen_q <= 1'b1;
            if (!dontstop_on_trap_i) begin
              state     <= ST_DRAIN;
              drain_cnt <= 32'(STOP_DELAY);
              reason_q  <= REASON_TRAP;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 32'd0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 32'd1;
          end
        end
        ST_DONE: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  mem_sig_fifo #(
    .T     (dump_rec_t),
    .DEPTH (DUMP_FIFO_DEPTH)
  ) u_dump_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push_vld (push_vld),
    .push_dat (push_rec),
    .pop_rdy  (dump_ready_i),
    .pop_dat  (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign trap_seen_o     = trap_seen_q;
  assign done_o          = done_q;
  assign reason_o        = reason_q;
  assign dump_ovf_o      = ovf_q;
  assign dump_valid_o    = !fifo_empty;
  assign dump_is_float_o = head_rec.is_float;
  assign dump_idx_o      = head_rec.idx;
  assign dump_data_o     = DATA_WIDTH'(head_rec.data);

endmodule

// File: tb/tb_mem_sig_monitor.sv
// Directed + randomized bench for mem_sig_monitor against a queue-based reference model.
module tb_mem_sig_monitor;

  localparam int SD = 50;
  localparam int FD = 8;
`ifdef MEM_SIG_MONITOR_SIMLEN_EN
  localparam bit SIMLEN = 1'b1;
`else
  localparam bit SIMLEN = 1'b0;
`endif
  localparam logic [31:0] A_STOP = 32'h00;
  localparam logic [31:0] A_TRAP = 32'h08;
  localparam logic [31:0] A_INT  = 32'h10;
  localparam logic [31:0] A_FP   = 32'h18;

  logic        clk = 1'b0;
  logic        rst, req, we, dontstop, ready;
  logic [31:0] addr, simlen;
  logic [63:0] wdata;
  logic        trap_seen, done, dump_valid, dump_is_float, dump_ovf;
  logic [1:0]  reason;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;

  always #5 clk = ~clk;

  mem_sig_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .STOP_DELAY(SD), .DUMP_FIFO_DEPTH(FD)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .data_mem_req_i     (req),
    .data_mem_we_i      (we),
    .data_mem_addr_i    (addr),
    .data_mem_wdata_i   (wdata),
    .dontstop_on_trap_i (dontstop),
    .simlen_i           (simlen),
    .trap_seen_o        (trap_seen),
    .done_o             (done),
    .reason_o           (reason),
    .dump_valid_o       (dump_valid),
    .dump_ready_i       (ready),
    .dump_is_float_o    (dump_is_float),
    .dump_idx_o         (dump_idx),
    .dump_data_o        (dump_data),
    .dump_ovf_o         (dump_ovf)
  );

  // Reference model state
  typedef struct packed {
    logic        f;
    logic [4:0]  idx;
    logic [63:0] d;
  } rec_t;

  rec_t       mq[$];
  int         m_int_idx, m_fp_idx, stop_edge, edge_n, run_cnt;
  bit         m_trap, m_ovf, m_simlen_done;
  logic [1:0] m_reason;
  int         n_checks, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_int_idx     = 1;
    m_fp_idx      = 0;
    stop_edge     = -1;
    edge_n        = 0;
    run_cnt       = 0;
    m_trap        = 1'b0;
    m_ovf         = 1'b0;
    m_simlen_done = 1'b0;
    m_reason      = 2'd0;
  endfunction

  function automatic void model_push(input rec_t r);
    if (mq.size() < FD) mq.push_back(r);
    else m_ovf = 1'b1;
  endfunction

  // Applies the spec rules for one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit   running;
    rec_t r;
    if (rst) begin
      model_reset();
      return;
    end
    edge_n++;
    running = (stop_edge < 0) && !m_simlen_done;
    if (ready && mq.size() > 0) void'(mq.pop_front());
    if (running) begin
      if (SIMLEN && simlen != 0 && run_cnt == int'(simlen) - 1) begin
        m_simlen_done = 1'b1;
        m_reason      = 2'd3;
      end else if (req && we) begin
        if (addr == A_STOP) begin
          stop_edge = edge_n;
          m_reason  = 2'd1;
        end else if (addr == A_TRAP) begin
          m_trap = 1'b1;
          if (!dontstop) begin
            stop_edge = edge_n;
            m_reason  = 2'd2;
          end
        end else if (addr == A_INT) begin
          r.f = 1'b0; r.idx = 5'(m_int_idx); r.d = {32'h0, wdata[31:0]};
          model_push(r);
          m_int_idx = (m_int_idx == 31) ? 1 : m_int_idx + 1;
        end else if (addr == A_FP) begin
          r.f = 1'b1; r.idx = 5'(m_fp_idx); r.d = wdata;
          model_push(r);
          m_fp_idx = (m_fp_idx == 31) ? 0 : m_fp_idx + 1;
        end
      end
      run_cnt++;
    end
  endfunction

  task automatic check_all();
    bit exp_done;
    exp_done = m_simlen_done || (stop_edge >= 0 && edge_n >= stop_edge + SD + 1);
    chk("done", done, exp_done);
    chk("reason", reason, m_reason);
    chk("trap_seen", trap_seen, m_trap);
    chk("ovf", dump_ovf, m_ovf);
    chk("valid", dump_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("head_float", dump_is_float, mq[0].f);
      chk("head_idx", dump_idx, mq[0].idx);
      chk("head_data", dump_data, mq[0].d);
    end
  endtask

  task automatic cyc(input bit r, input bit rq, input bit w, input logic [31:0] a,
                     input logic [63:0] d, input bit rdy);
    rst = r; req = rq; we = w; addr = a; wdata = d; ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, rdy);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input bit rdy);
    cyc(1'b0, 1'b1, 1'b1, a, d, rdy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic rand_cycle();
    logic [31:0] a;
    int          sel;
    sel = $urandom_range(0, 9);
    if (sel <= 3)      a = A_INT;
    else if (sel <= 6) a = A_FP;
    else               a = 32'h100 + 32'($urandom_range(0, 63) * 8);
    cyc(1'b0, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, a,
        {$urandom, $urandom}, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ready = 1'b0; dontstop = 1'b0; simlen = '0;
    model_reset();

    // Reset state
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_reason", reason, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_idx", dump_idx, 0);

    // Record formatting and ordering
    wr(A_INT, 64'hDEAD_BEEF_1234_5678, 1'b0);
    wr(A_INT, 64'h5, 1'b0);
    wr(A_FP, 64'h3FF0_0000_0000_0000, 1'b0);
    chk("rec0_float", dump_is_float, 0);
    chk("rec0_idx", dump_idx, 1);
    chk("rec0_data", dump_data, 64'h1234_5678);
    idle(1, 1'b1);
    chk("rec1_float", dump_is_float, 0);
    chk("rec1_idx", dump_idx, 2);
    chk("rec1_data", dump_data, 64'h5);
    idle(1, 1'b1);
    chk("rec2_float", dump_is_float, 1);
    chk("rec2_idx", dump_idx, 0);
    chk("rec2_data", dump_data, 64'h3FF0_0000_0000_0000);
    idle(1, 1'b1);
    chk("recs_drained", dump_valid, 0);

    // Random dump traffic, long enough to wrap the register indices
    for (int i = 0; i < 150; i++) rand_cycle();

    // Trap that does not stop
    dontstop = 1'b1;
    wr(A_TRAP, {$urandom, $urandom}, 1'b1);
    chk("trap_cont_seen", trap_seen, 1);
    chk("trap_cont_done", done, 0);
    wr(A_INT, 64'h77, 1'b0);
    chk("trap_cont_dump", dump_valid, 1);
    for (int i = 0; i < 20; i++) rand_cycle();
    dontstop = 1'b0;

    // Overflow with ready held low
    do_reset();
    for (int i = 0; i < 10; i++) wr(A_INT, {$urandom, $urandom}, 1'b0);
    chk("ovf_set", dump_ovf, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order_idx", dump_idx, 64'(i + 1));
      idle(1, 1'b1);
    end
    chk("ovf_empty", dump_valid, 0);

    // Stop write timing and ignored writes while draining
    do_reset();
    idle(98, 1'b1);
    wr(A_STOP, 64'h0, 1'b1);
    chk("stop_reason", reason, 1);
    chk("stop_not_done", done, 0);
    idle(19, 1'b1);
    wr(A_INT, 64'h99, 1'b0);
    chk("drain_no_dump", dump_valid, 0);
    idle(30, 1'b0);
    chk("stop_done_early", done, 0);
    idle(1, 1'b0);
    chk("stop_done", done, 1);
    wr(A_TRAP, 64'h0, 1'b0);
    chk("done_no_trap", trap_seen, 0);

    // Trap that stops
    do_reset();
    idle(3, 1'b1);
    wr(A_TRAP, 64'h1, 1'b1);
    chk("trap_reason", reason, 2);
    chk("trap_seen", trap_seen, 1);
    wr(A_STOP, 64'h0, 1'b1);
    chk("trap_reason_held", reason, 2);
    idle(SD - 1, 1'b1);
    chk("trap_done_early", done, 0);
    idle(1, 1'b1);
    chk("trap_done", done, 1);

    // Reset in the middle of a drain
    do_reset();
    wr(A_INT, 64'h1234, 1'b0);
    wr(A_TRAP, 64'h0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    chk("mid_rst_trap", trap_seen, 0);
    chk("mid_rst_reason", reason, 0);
    chk("mid_rst_valid", dump_valid, 0);
    chk("mid_rst_data", dump_data, 0);
    wr(A_INT, 64'h42, 1'b0);
    chk("mid_rst_idx", dump_idx, 1);
    chk("mid_rst_dump", dump_valid, 1);

`ifdef MEM_SIG_MONITOR_SIMLEN_EN
    simlen = 32'd20;
    do_reset();
    idle(19, 1'b1);
    wr(A_STOP, 64'h0, 1'b1);
    chk("simlen_done", done, 1);
    chk("simlen_reason", reason, 3);
    simlen = 32'd0;
`else
    simlen = 32'd20;
    do_reset();
    idle(30, 1'b1);
    chk("no_simlen_done", done, 0);
    simlen = 32'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sig_monitor.md
# mem_sig_monitor

Synthesizable monitor that sits directly downstream of the tiny SoC's data-memory port and decodes software-signalling writes: stop request, trap signal, integer and float register dumps. It replaces ad-hoc bench polling with a cycle-exact engine. Outputs:

- a done/reason pair for the harness;
- a buffered stream of register-dump records for a logger or trace port.

## Interface
Parameters:
- ADDR_WIDTH, 32, data-memory address width
- DATA_WIDTH, 64, data-memory write-data width
- STOP_DELAY, 50, cycles drained after a stop/trap before done
- DUMP_FIFO_DEPTH, 8, dump-record buffer entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- data_mem_req_i  in  1  DUT data request
- data_mem_we_i  in  1  DUT write enable
- data_mem_addr_i  in  ADDR_WIDTH  DUT address
- data_mem_wdata_i  in  DATA_WIDTH  DUT write data
- dontstop_on_trap_i  in  1  1: trap writes are logged but do not stop
- simlen_i  in  32  cycle limit; 0 disables (only with SIMLEN_EN)
- trap_seen_o  out  1  sticky, any trap write seen in RUN
- done_o  out  1  sticky, monitoring finished
- reason_o  out  2  0 none, 1 stop write, 2 trap, 3 simlen
- dump_valid_o  out  1  dump record available
- dump_ready_i  in  1  consumer accepts record
- dump_is_float_o  out  1  record is f-register
- dump_idx_o  out  5  register index
- dump_data_o  out  DATA_WIDTH  record payload
- dump_ovf_o  out  1  sticky, record dropped on full FIFO

## Operation
- Address map: STOP 0x00, TRAP 0x08, INT_DUMP 0x10, FP_DUMP 0x18.
- A write is captured when req && we, sampled on the rising edge. gnt is ignored.
- States:
  - RUN: decode all addresses; cycle counter increments.
  - DRAIN: decoding disabled; drain counter decrements.
  - DONE: terminal until reset.
- RUN transitions:
  - Write to STOP: go to DRAIN with drain counter = STOP_DELAY, reason 1.
  - Write to TRAP: set trap_seen_o. If !dontstop_on_trap_i, go to DRAIN with reason 2; otherwise stay in RUN.
- DRAIN → DONE on the edge where the drain counter is 0. STOP_DELAY=0 gives a single DRAIN cycle.
- Register dumps (RUN only):
  - INT_DUMP pushes {0, int_idx, wdata & 0xFFFF_FFFF}. int_idx resets to 1 and wraps 31→1.
  - FP_DUMP pushes {1, fp_idx, wdata}. fp_idx resets to 0 and wraps 31→0.
  - The index advances even if the record is dropped.
- FIFO full on push: drop the record and set dump_ovf_o. A push and pop in the same cycle when full is accepted.
- Writes in DRAIN or DONE are ignored; no dumps, no trap_seen update.
- Reset values: done_o, trap_seen_o, dump_valid_o, dump_ovf_o = 0; reason_o = 0; dump_* data outputs = 0. FIFO is emptied and the state is RUN.
- Reset mid-DRAIN returns to RUN with all counters reset. Undrained records are discarded.

## Timing
- Dump record appears on dump_valid_o one cycle after the capturing edge (registered FIFO, no fall-through).
- dump_valid/ready is a standard handshake: a record transfers when both are high. Payload is held stable while valid && !ready.
- done_o rises STOP_DELAY+1 cycles after the edge that captured the stop/trap write. reason_o updates on the capture edge.
- Simlen: when the cycle counter equals simlen_i-1 in RUN, go directly to DONE on that edge with reason 3. This takes priority over a same-cycle STOP/TRAP write; that write is ignored.
- The cycle counter is 32-bit and saturates; it does not wrap.

## Configuration
- MEM_SIG_MONITOR_SIMLEN_EN defined: the cycle counter and simlen stop are present.
- Not defined: simlen_i is unused, the counter logic is removed, and reason 3 is never produced.

## Structure
- Package mem_sig_monitor_pkg holds:
  - address constants ADDR_STOP_SIG, ADDR_TRAP_SIG, ADDR_INT_DUMP, ADDR_FP_DUMP;
  - dump_rec_t {is_float, idx[4:0], data};
  - stop_reason_e;
  - the state enum.
- Sub-module mem_sig_fifo: a generic sync FIFO parameterized by type and depth, with full/empty and a registered head.

## Test plan
- INT_DUMP writes 0xDEAD_BEEF_1234_5678 and then 0x5 → records {0,1,0x1234_5678} and {0,2,0x5}; FP_DUMP 0x3FF0_0000_0000_0000 → {1,0,0x3FF0_0000_0000_0000}.
- STOP write at cycle 100 with STOP_DELAY=50 → reason_o=1 at 101 and done_o at 151; an INT_DUMP at 120 produces no record.
- TRAP write with dontstop_on_trap_i=1 → trap_seen_o=1, state stays RUN, later dumps still logged. With dontstop_on_trap_i=0 → reason 2 and done after STOP_DELAY+1 cycles.
- dump_ready_i held 0 and 10 INT_DUMPs with depth 8 → 8 records retained, dump_ovf_o=1; releasing ready yields indices 1..8 in order.
- SIMLEN_EN with simlen_i=20 and a STOP write on cycle 19 → done_o with reason 3 immediately, no drain. With simlen_i=0, no simlen stop occurs.
- Assert rst_i during DRAIN → all outputs 0 the next cycle; a subsequent INT_DUMP restarts at idx 1.
